// File: rtl/srlatch_pkg.sv
// Shared constants for the SR latch driver: FSM state encoding and default timing.
package srlatch_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DRIVE_S = 2'd1;
  localparam logic [1:0] DRIVE_R = 2'd2;
  localparam logic [1:0] GAP     = 2'd3;

  localparam int PULSE_W_DEF = 4;
  localparam int GAP_W_DEF   = 2;
  localparam int CNT_W_DEF   = 4;

endpackage

// File: rtl/srlatch_pulse_cnt.sv
// Loadable down-counter with zero flag; holds at zero rather than wrapping.
module srlatch_pulse_cnt
  import srlatch_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/srlatch_driver.sv
// Drives s/r of an asynchronous NOR SR latch with fixed-width pulses and a quiet gap.
// Optional feedback check of q_fb against q_model: define SRLATCH_DRIVER_FB_CHECK_EN.
//
// state   | meaning
// IDLE    | waiting for req_set / req_reset
// DRIVE_S | s held high for PULSE_W cycles
// DRIVE_R | r held high for PULSE_W cycles
// GAP     | s=r=0 for GAP_W cycles, done in last cycle
module srlatch_driver
  import srlatch_pkg::*;
#(
  parameter int PULSE_W = PULSE_W_DEF,
  parameter int GAP_W   = GAP_W_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic req_set,
  input  logic req_reset,
  input  logic q_fb,
  output logic s,
  output logic r,
  output logic busy,
  output logic done,
  output logic q_model,
  output logic err
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt;
  logic             cnt_zero;

  srlatch_pulse_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // Reset wins when both requests arrive together.
  always_comb begin
    state_nxt    = state;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_dec      = 1'b0;
    case (state)
      IDLE: begin
        if (req_reset) begin
          state_nxt    = DRIVE_R;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LD;
        end else if (req_set) begin
          state_nxt    = DRIVE_S;
          cnt_load     = 1'b1;
          cnt_load_val = PULSE_LD;
        end
      end
      DRIVE_S, DRIVE_R: begin
        if (cnt_zero) begin
          state_nxt    = GAP;
          cnt_load     = 1'b1;
          cnt_load_val = GAP_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: begin
        if (cnt_zero) begin
          state_nxt = IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
    endcase
  end

  // s and r come straight from flops decoded off a single next-state value,
  // so the latch never sees a glitch or both drives high at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      s       <= 1'b0;
      r       <= 1'b0;
      q_model <= 1'b0;
    end else begin
      state <= state_nxt;
      s     <= (state_nxt == DRIVE_S);
      r     <= (state_nxt == DRIVE_R);
      if (state == IDLE && state_nxt == DRIVE_S) begin
        q_model <= 1'b1;
      end else if (state == IDLE && state_nxt == DRIVE_R) begin
        q_model <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == GAP) && cnt_zero;

`ifdef SRLATCH_DRIVER_FB_CHECK_EN
  logic err_q;
  logic fb_mismatch;

  assign fb_mismatch = done && (q_fb != q_model);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (fb_mismatch) begin
      err_q <= 1'b1;
    end
  end

  // Flag the mismatch in the done cycle itself, then hold it.
  assign err = err_q | fb_mismatch;
`else
  logic unused_q_fb;

  assign unused_q_fb = q_fb;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_srlatch_driver.sv
// Directed and random checks for srlatch_driver (PULSE_W=4, GAP_W=2).
module tb_srlatch_driver;

  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_set = 1'b0;
  logic req_reset = 1'b0;
  logic q_fb = 1'b0;
  logic s, r, busy, done, q_model, err;

  int checks = 0;
  int errors = 0;

  srlatch_driver #(.PULSE_W(4), .GAP_W(2), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_set   (req_set),
    .req_reset (req_reset),
    .q_fb      (q_fb),
    .s         (s),
    .r         (r),
    .busy      (busy),
    .done      (done),
    .q_model   (q_model),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Window k=0 is the request cycle; k=1..6 cover pulse, gap and done.
  // Returns at the negedge of k=7, which is the next window's k=0.
  task automatic run_cmd(input string tag, input logic rs, input logic rr,
                         input logic [6:0] s_exp, input logic [6:0] r_exp,
                         input logic q_prev, input logic q_new,
                         input int inj_k, input logic inj_s, input logic inj_r);
    logic [6:0] busy_exp;
    logic [6:0] done_exp;
    busy_exp = 7'b1111110;
    done_exp = 7'b1000000;
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("%s_s_k%0d", tag, k), s, s_exp[k]);
      chk($sformatf("%s_r_k%0d", tag, k), r, r_exp[k]);
      chk($sformatf("%s_busy_k%0d", tag, k), busy, busy_exp[k]);
      chk($sformatf("%s_done_k%0d", tag, k), done, done_exp[k]);
      chk($sformatf("%s_q_k%0d", tag, k), q_model, (k == 0) ? q_prev : q_new);
      chk($sformatf("%s_sr_k%0d", tag, k), s & r, 1'b0);
      req_set   = (k == 0) ? rs : ((k == inj_k) ? inj_s : 1'b0);
      req_reset = (k == 0) ? rr : ((k == inj_k) ? inj_r : 1'b0);
      tick();
    end
    req_set   = 1'b0;
    req_reset = 1'b0;
  endtask

  int s_run = 0;
  int r_run = 0;
  int accepted = 0;
  int dones = 0;

  task automatic observe();
    chk("rand_s_and_r", s & r, 1'b0);
    if (s) s_run++;
    else if (s_run != 0) begin
      chk_int("rand_s_width", s_run, PW);
      s_run = 0;
    end
    if (r) r_run++;
    else if (r_run != 0) begin
      chk_int("rand_r_width", r_run, PW);
      r_run = 0;
    end
    if (done) dones++;
  endtask

  localparam logic [6:0] PULSE = 7'b0011110;
  localparam logic [6:0] NONE  = 7'b0000000;

  initial begin
    rst = 1'b1;
    tick();
    chk("rst_s", s, 1'b0);
    chk("rst_r", r, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_q", q_model, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 1'b0);

    // Set with a reset request arriving mid-pulse (ignored), then reset right after done.
    run_cmd("set1", 1'b1, 1'b0, PULSE, NONE, 1'b0, 1'b1, 3, 1'b0, 1'b1);
    run_cmd("rst1", 1'b0, 1'b1, NONE, PULSE, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    // Request in the done cycle is dropped; following window starts idle.
    run_cmd("set2", 1'b1, 1'b0, PULSE, NONE, 1'b0, 1'b1, 6, 1'b1, 1'b0);
    run_cmd("set_redund", 1'b1, 1'b0, PULSE, NONE, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    run_cmd("both", 1'b1, 1'b1, NONE, PULSE, 1'b1, 1'b0, -1, 1'b0, 1'b0);
    chk("after_both_busy", busy, 1'b0);
    chk("default_err", err, 1'b0);

    // Asynchronous reset in the middle of a set pulse.
    req_set = 1'b1;
    tick();
    req_set = 1'b0;
    tick();
    chk("mid_s_before", s, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_s", s, 1'b0);
    chk("mid_rst_r", r, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_q", q_model, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    run_cmd("post_rst", 1'b1, 1'b0, PULSE, NONE, 1'b0, 1'b1, -1, 1'b0, 1'b0);

    // Random traffic.
    s_run = 0;
    r_run = 0;
    for (int i = 0; i < 3000; i++) begin
      observe();
      req_set   = ($urandom_range(0, 3) == 0);
      req_reset = ($urandom_range(0, 4) == 0);
      if (!busy && (req_set || req_reset)) accepted++;
      tick();
    end
    req_set   = 1'b0;
    req_reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      observe();
      tick();
    end
    chk_int("rand_done_count", dones, accepted);
    chk("rand_some_accepted", accepted > 50, 1'b1);

`ifdef SRLATCH_DRIVER_FB_CHECK_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_fb = 1'b0;
    req_set = 1'b1;
    tick();
    req_set = 1'b0;
    for (int k = 1; k < 6; k++) begin
      chk($sformatf("fb_err_pre_k%0d", k), err, 1'b0);
      tick();
    end
    chk("fb_done", done, 1'b1);
    chk("fb_err_done", err, 1'b1);
    tick();
    q_fb = 1'b1;
    run_cmd("fb_next", 1'b1, 1'b0, PULSE, NONE, 1'b1, 1'b1, -1, 1'b0, 1'b0);
    chk("fb_err_sticky", err, 1'b1);
    rst = 1'b1;
    tick();
    chk("fb_err_cleared", err, 1'b0);
    rst = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
